// File: rtl/rv_pkg.sv
// ============================================================================
//  Module      : rv_pkg
//  Description : RV32I decode constants: datapath widths, opcode values,
//                immediate-format enum and the immediate generator helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int PC_W   = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    // Only bits [31:7] carry immediate information; the opcode is not needed.
    function automatic logic [XLEN-1:0] imm_gen(input imm_fmt_e fmt, input logic [31:7] ins);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode_stage_if.sv
// ============================================================================
//  Module      : instr_decode_stage_if
//  Description : Fetch-side, writeback and execute-side signals of the decode
//                stage. slave = decode stage, master = surrounding pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_decode_stage_if;
    import rv_pkg::*;

    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [PC_W-1:0]   if_pc;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              id_valid;
    logic              id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_val;
    logic [XLEN-1:0]   id_rs2_val;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rd;
    logic [6:0]        id_opcode;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              id_illegal;

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, id_ready,
        input  if_ready, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd,
               id_opcode, id_funct3, id_funct7, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, id_ready,
        output if_ready, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd,
               id_opcode, id_funct3, id_funct7, id_illegal
    );

endinterface

`default_nettype wire

// File: rtl/rv_regfile.sv
// ============================================================================
//  Module      : rv_regfile
//  Description : DEPTH x DATA_W register file, two asynchronous read ports,
//                one synchronous write port, x0 hardwired to zero, cleared
//                asynchronously by rst.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [ADDR_W-1:0] raddr1_i,
    output logic      [DATA_W-1:0] rdata1_o,
    input  wire logic [ADDR_W-1:0] raddr2_i,
    output logic      [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Register array: cleared on reset, written on the edge unless targeting x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
// ============================================================================
//  Module      : instr_decode_stage
//  Description : RV32I decode stage. Field extraction, immediate generation,
//                illegal-encoding detection and register-file read feed a
//                single output bundle register with a valid/ready handshake.
//  Config      : ID_BYPASS_EN - when defined, a writeback to a source register
//                on the accept edge is forwarded into the captured operand.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decode_stage
    import rv_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    instr_decode_stage_if.slave bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rf_rs1, w_rf_rs2, w_rs1_val, w_rs2_val;
    imm_fmt_e          w_fmt;
    logic              w_illegal;
    logic              w_if_ready;
    logic              w_accept;

    logic [PC_W-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_q, rs2_q, imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [6:0]        opcode_q, funct7_q;
    logic [2:0]        funct3_q;
    logic              illegal_q;

    assign w_opcode = bus.if_instr[6:0];
    assign w_rd     = bus.if_instr[11:7];
    assign w_funct3 = bus.if_instr[14:12];
    assign w_rs1    = bus.if_instr[19:15];
    assign w_rs2    = bus.if_instr[24:20];
    assign w_funct7 = bus.if_instr[31:25];

    assign w_if_ready = (state_q == ST_EMPTY) || bus.id_ready;
    assign w_accept   = bus.if_valid && w_if_ready && !bus.flush;

    rv_regfile #(
        .DATA_W (XLEN),
        .DEPTH  (NREG),
        .ADDR_W (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_en),
        .waddr_i  (bus.wb_rd),
        .wdata_i  (bus.wb_data),
        .raddr1_i (w_rs1),
        .rdata1_o (w_rf_rs1),
        .raddr2_i (w_rs2),
        .rdata2_o (w_rf_rs2)
    );

`ifdef ID_BYPASS_EN
    assign w_rs1_val = (bus.wb_en && (bus.wb_rd == w_rs1) && (w_rs1 != '0)) ? bus.wb_data : w_rf_rs1;
    assign w_rs2_val = (bus.wb_en && (bus.wb_rd == w_rs2) && (w_rs2 != '0)) ? bus.wb_data : w_rf_rs2;
`else
    assign w_rs1_val = w_rf_rs1;
    assign w_rs2_val = w_rf_rs2;
`endif

    // Immediate format selection and illegal-encoding detection.
    always_comb begin
        w_fmt     = IMM_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (!((w_funct7 == F7_BASE) ||
                      ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_fmt = IMM_I;
                // Only the shift encodings constrain funct7; SRAI is the lone ALT form.
                if ((w_funct3 == 3'b001) && (w_funct7 != F7_BASE)) begin
                    w_illegal = 1'b1;
                end
                if ((w_funct3 == 3'b101) && (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT)) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR:  w_fmt = IMM_I;
            OPC_STORE:           w_fmt = IMM_S;
            OPC_BRANCH:          w_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:  w_fmt = IMM_U;
            OPC_JAL:             w_fmt = IMM_J;
            OPC_SYSTEM:          w_fmt = IMM_NONE;
            default:             w_illegal = 1'b1;
        endcase
        if (bus.if_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush wins over accept, accept wins over drain.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (w_accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && bus.id_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Output bundle bank: loads only on accept, so a stalled or flushed bundle stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            illegal_q <= 1'b0;
        end else if (w_accept) begin
            pc_q      <= bus.if_pc;
            rs1_q     <= w_rs1_val;
            rs2_q     <= w_rs2_val;
            imm_q     <= imm_gen(w_fmt, bus.if_instr[31:7]);
            rd_q      <= w_rd;
            opcode_q  <= w_opcode;
            funct3_q  <= w_funct3;
            funct7_q  <= w_funct7;
            illegal_q <= w_illegal;
        end
    end

    assign bus.if_ready   = w_if_ready;
    assign bus.id_valid   = (state_q == ST_FULL);
    assign bus.id_pc      = pc_q;
    assign bus.id_rs1_val = rs1_q;
    assign bus.id_rs2_val = rs2_q;
    assign bus.id_imm     = imm_q;
    assign bus.id_rd      = rd_q;
    assign bus.id_opcode  = opcode_q;
    assign bus.id_funct3  = funct3_q;
    assign bus.id_funct7  = funct7_q;
    assign bus.id_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Self-checking bench for instr_decode_stage. Accepted
//                instructions push an expected bundle to a queue; the monitor
//                compares the head against the outputs while id_valid is high.
//  Config      : ID_BYPASS_EN selects the expected operand on same-edge writes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_stage;

    logic clk;
    logic rst;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] tb_regs [32];
    logic [31:0] drv_imm;
    logic        drv_ill;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference register file, updated from the writeback the bench drives.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) tb_regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            tb_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    function automatic logic [31:0] exp_rs(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_BYPASS_EN
        if (bus.wb_en && (bus.wb_rd == idx)) return bus.wb_data;
`endif
        return tb_regs[idx];
    endfunction

    // Monitor: check the head while valid, retire it on transfer or flush,
    // then record any instruction accepted on the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.id_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_valid", 32'd1, 32'd0);
                end else begin
                    chk("id_pc",  bus.id_pc,      sb_q[0].pc);
                    chk("id_rs1", bus.id_rs1_val, sb_q[0].rs1);
                    chk("id_rs2", bus.id_rs2_val, sb_q[0].rs2);
                    chk("id_imm", bus.id_imm,     sb_q[0].imm);
                    chk("id_rd",  {27'd0, bus.id_rd},     {27'd0, sb_q[0].rd});
                    chk("id_opc", {25'd0, bus.id_opcode}, {25'd0, sb_q[0].opc});
                    chk("id_f3",  {29'd0, bus.id_funct3}, {29'd0, sb_q[0].f3});
                    chk("id_f7",  {25'd0, bus.id_funct7}, {25'd0, sb_q[0].f7});
                    chk("id_ill", {31'd0, bus.id_illegal}, {31'd0, sb_q[0].ill});
                    if (bus.id_ready || bus.flush) void'(sb_q.pop_front());
                end
            end
            if (bus.if_valid && bus.if_ready && !bus.flush) begin
                exp_t e;
                e.pc  = bus.if_pc;
                e.rs1 = exp_rs(bus.if_instr[19:15]);
                e.rs2 = exp_rs(bus.if_instr[24:20]);
                e.imm = drv_imm;
                e.rd  = bus.if_instr[11:7];
                e.opc = bus.if_instr[6:0];
                e.f3  = bus.if_instr[14:12];
                e.f7  = bus.if_instr[31:25];
                e.ill = drv_ill;
                sb_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic ill);
        logic ok;
        ok = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        drv_imm      = imm;
        drv_ill      = ill;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.if_ready;
            tick();
        end
        bus.if_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    // instr, expected imm, expected illegal
    logic [31:0] t_ins [17] = '{
        32'hFE000EE3, 32'hFE000E63, 32'h123450B7, 32'hFE20AE23, 32'h008000EF,
        32'h00008067, 32'h00001217, 32'hFFF00093, 32'h402081B3, 32'h4030D093,
        32'h00000073, 32'h00812083, 32'h0000007F, 32'h022081B3, 32'h402091B3,
        32'h40309093, 32'h00500090 };
    logic [31:0] t_imm [17] = '{
        32'hFFFFFFFC, 32'hFFFFF7FC, 32'h12345000, 32'hFFFFFFFC, 32'h00000008,
        32'h00000000, 32'h00001000, 32'hFFFFFFFF, 32'h00000000, 32'h00000403,
        32'h00000000, 32'h00000008, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000403, 32'h00000000 };
    logic        t_ill [17] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1 };

    initial begin
        rst          = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.flush    = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.id_ready = 1'b1;
        drv_imm      = '0;
        drv_ill      = 1'b0;

        #1;
        chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_pc",    bus.id_pc,      32'd0);
        chk("rst_rs1",   bus.id_rs1_val, 32'd0);
        chk("rst_imm",   bus.id_imm,     32'd0);
        chk("rst_ill",   {31'd0, bus.id_illegal}, 32'd0);
        chk("rst_ifrdy", {31'd0, bus.if_ready}, 32'd1);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // addi x1,x0,5 : one-cycle latency
        send(32'h00500093, 32'h10, 32'd5, 1'b0);
        chk("lat_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("addi_imm",  bus.id_imm, 32'd5);
        chk("addi_rd",   {27'd0, bus.id_rd}, 32'd1);
        chk("addi_pc",   bus.id_pc, 32'h10);

        // register file write / read, x0 stays zero
        wb(5'd1, 32'hDEAD);
        wb(5'd2, 32'h1234);
        send(32'h002081B3, 32'h14, 32'd0, 1'b0);
        chk("add_rs1", bus.id_rs1_val, 32'hDEAD);
        chk("add_rs2", bus.id_rs2_val, 32'h1234);
        wb(5'd0, 32'hFFFF);
        send(32'h000001B3, 32'h18, 32'd0, 1'b0);
        chk("x0_read", bus.id_rs1_val, 32'd0);

        // immediate formats and illegal encodings
        for (int k = 0; k < 17; k++) begin
            send(t_ins[k], 32'h40 + 32'(k) * 4, t_imm[k], t_ill[k]);
        end

        // back-pressure: hold for 3 cycles, then next instruction in one cycle
        tick();
        bus.id_ready = 1'b0;
        send(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 1'b0);
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h00001217;
        bus.if_pc    = 32'h104;
        drv_imm      = 32'h1000;
        drv_ill      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ifrdy", {31'd0, bus.if_ready}, 32'd0);
            chk("hold_pc",    bus.id_pc, 32'h100);
            tick();
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("rel_ifrdy", {31'd0, bus.if_ready}, 32'd1);
        tick();
        bus.if_valid = 1'b0;
        chk("rel_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("rel_pc",    bus.id_pc, 32'h104);

        // flush on the accept cycle
        repeat (2) tick();
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h008000EF;
        bus.if_pc    = 32'h180;
        bus.flush    = 1'b1;
        tick();
        bus.if_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_acc_v", {31'd0, bus.id_valid}, 32'd0);

        // flush of a held bundle keeps its data
        bus.id_ready = 1'b0;
        send(32'h008000EF, 32'h200, 32'd8, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_hold_v",  {31'd0, bus.id_valid}, 32'd0);
        chk("flush_hold_pc", bus.id_pc, 32'h200);
        bus.id_ready = 1'b1;

        // writeback to x5 on the same edge as accept of addi x6,x5,0
        wb(5'd5, 32'h11);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd5;
        bus.wb_data = 32'h55;
        send(32'h00028313, 32'h220, 32'd0, 1'b0);
        bus.wb_en   = 1'b0;
`ifdef ID_BYPASS_EN
        chk("byp_rs1", bus.id_rs1_val, 32'h55);
`else
        chk("byp_rs1", bus.id_rs1_val, 32'h11);
`endif

        // reset in the middle of a held bundle
        wb(5'd7, 32'h77);
        bus.id_ready = 1'b0;
        send(32'h000381B3, 32'h300, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("mrst_pc",    bus.id_pc, 32'd0);
        tick();
        rst          = 1'b0;
        bus.id_ready = 1'b1;
        tick();
        send(32'h000381B3, 32'h304, 32'd0, 1'b0);
        chk("mrst_rf", bus.id_rs1_val, 32'd0);

        // drain
        for (int n = 0; n < 20 && (sb_q.size() != 0 || bus.id_valid); n++) tick();
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
